change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15; the number of cycles a coin offer may stall before a fault is declared.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port if_sell, input, 1 bit; a one-cycle sale-complete strobe from the vending core.
REQ-005 SHALL have port charge, input, 8 bits; the unsigned change amount, valid only in the cycle if_sell is high.
REQ-006 SHALL have port hopper_ready, input, 1 bit; the coin hopper accepts the offered coin in this cycle.
REQ-007 SHALL have port coin_valid, output, 1 bit; a coin is offered to the hopper.
REQ-008 SHALL have port coin_value, output, 2 bits; the offered coin code: 00=1, 01=5, 10=10, 11=50.
REQ-009 SHALL have port remaining, output, 8 bits; the change still owed.
REQ-010 SHALL have port coin_count, output, 5 bits; the number of coins transferred in the current payout.
REQ-011 SHALL have port busy, output, 1 bit; high when the block is in DISPENSE.
REQ-012 SHALL have port done, output, 1 bit; a one-cycle pulse when a payout completes.
REQ-013 SHALL have port fault, output, 1 bit; hopper timeout, sticky until reset.

Function
REQ-014 SHALL implement the states IDLE, DISPENSE, DONE and FAULT.
REQ-015 IDLE with if_sell=1 SHALL latch remaining<=charge and clear coin_count; the next state is DISPENSE if charge!=0, else DONE.
REQ-016 SHALL assert coin_valid only in DISPENSE, so the first offer appears in the cycle after if_sell.
REQ-017 coin_value SHALL be the greedy choice from the registered remaining: 50 if remaining>=50, else 10 if >=10, else 5 if >=5, else 1.
REQ-018 A transfer SHALL occur on coin_valid & hopper_ready.
REQ-019 On a transfer, remaining SHALL decrease by the coin value and coin_count SHALL increment, both registered.
REQ-020 While coin_valid is high and hopper_ready is low, coin_value SHALL be held stable.
REQ-021 A transfer that brings remaining to 0 SHALL move the state to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 remaining and coin_count SHALL hold their values in IDLE until the next if_sell.
REQ-024 if_sell asserted in DISPENSE, DONE or FAULT SHALL be ignored, leaving remaining unchanged.
REQ-025 A wait counter SHALL increment each DISPENSE cycle with coin_valid & ~hopper_ready, and SHALL clear on a transfer.
REQ-026 When the wait counter reaches MAX_WAIT, the next state SHALL be FAULT.
REQ-027 FAULT SHALL drive coin_valid=0, busy=0, fault=1, and hold remaining; it is exited only by rst.
REQ-028 The arithmetic SHALL be 8-bit unsigned; the greedy rule guarantees no underflow; worst case is 13 coins (charge 249).

Reset
REQ-029 rst SHALL force IDLE with remaining=0, coin_count=0, wait counter=0, and coin_valid, coin_value, busy, done, fault all 0.
REQ-030 rst asserted mid-DISPENSE SHALL abandon the payout immediately, with no further coin offers.

Structure
REQ-031 Shared package vend_pkg SHALL hold the coin code constants, the coin values (1/5/10/50) and the state encoding.
REQ-032 The greedy selection SHALL be the combinational sub-module coin_select (remaining in; coin code and value out).

Verification
REQ-033 charge=20 with if_sell and hopper_ready=1 -> coins 10,10 on consecutive cycles, coin_count=2, done one cycle after the second transfer.
REQ-034 charge=90 with hopper_ready=1 -> coins 50,10,10,10,10, coin_count=5, remaining=0.
REQ-035 charge=0 with if_sell -> no coin_valid, done pulse in the next cycle, then IDLE.
REQ-036 charge=249 with hopper_ready toggling every other cycle -> 4x50, 4x10, 1x5, 4x1, coin_value stable during stalls, coin_count=13.
REQ-037 charge=30 with hopper_ready held low -> fault rises after 15 stalled cycles, coin_valid=0, remaining=30; if_sell=1 with charge=40 in FAULT is ignored (remaining stays 30); rst returns to IDLE.
REQ-038 charge=60 with rst asserted after the first transfer -> all outputs go to 0 asynchronously; a new if_sell with charge=5 then yields a single 5 coin.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin codes, coin amounts, widths and FSM state encoding for the change dispenser.
package vend_pkg;

  localparam int unsigned AMT_W   = 8;
  localparam int unsigned COUNT_W = 5;
  localparam int unsigned CODE_W  = 2;

  localparam logic [CODE_W-1:0] COIN_1  = 2'b00;
  localparam logic [CODE_W-1:0] COIN_5  = 2'b01;
  localparam logic [CODE_W-1:0] COIN_10 = 2'b10;
  localparam logic [CODE_W-1:0] COIN_50 = 2'b11;

  localparam logic [AMT_W-1:0] VAL_1  = 8'd1;
  localparam logic [AMT_W-1:0] VAL_5  = 8'd5;
  localparam logic [AMT_W-1:0] VAL_10 = 8'd10;
  localparam logic [AMT_W-1:0] VAL_50 = 8'd50;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

endpackage

// File: rtl/coin_select.sv
// Greedy coin choice: largest coin not exceeding the amount still owed.
module coin_select
  import vend_pkg::*;
(
  input  logic [AMT_W-1:0]  remaining,
  output logic [CODE_W-1:0] code,
  output logic [AMT_W-1:0]  value
);

  // Largest-first selection; amounts below 5 (including 0) fall back to the 1 coin.
  always_comb begin
    code  = COIN_1;
    value = VAL_1;
    if (remaining >= VAL_50) begin
      code  = COIN_50;
      value = VAL_50;
    end else if (remaining >= VAL_10) begin
      code  = COIN_10;
      value = VAL_10;
    end else if (remaining >= VAL_5) begin
      code  = COIN_5;
      value = VAL_5;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time to a handshaked hopper,
// with a stall timeout that latches a fault until reset.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_sell,
  input  logic [AMT_W-1:0]   charge,
  input  logic               hopper_ready,
  output logic               coin_valid,
  output logic [CODE_W-1:0]  coin_value,
  output logic [AMT_W-1:0]   remaining,
  output logic [COUNT_W-1:0] coin_count,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [AMT_W-1:0]  coin_amt;
  logic [AMT_W-1:0]  rem_after;
  logic [AMT_W-1:0]  sel_in;
  logic [CODE_W-1:0] sel_code;
  logic [AMT_W-1:0]  sel_value;
  logic              transfer;
  logic              stall;

  // The coin offered next is chosen from the amount that will be owed after this edge,
  // so coin_value can be registered alongside remaining.
  assign rem_after = remaining - coin_amt;
  assign sel_in    = (state == ST_IDLE) ? charge : rem_after;
  assign transfer  = coin_valid & hopper_ready;
  assign stall     = coin_valid & ~hopper_ready;

  coin_select u_coin_select (
    .remaining (sel_in),
    .code      (sel_code),
    .value     (sel_value)
  );

  // Payout FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      coin_count <= '0;
      wait_cnt   <= '0;
      coin_amt   <= VAL_1;
      coin_valid <= 1'b0;
      coin_value <= COIN_1;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_sell) begin
            remaining  <= charge;
            coin_count <= '0;
            wait_cnt   <= '0;
            coin_value <= sel_code;
            coin_amt   <= sel_value;
            if (charge != '0) begin
              state      <= ST_DISPENSE;
              coin_valid <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DISPENSE: begin
          if (transfer) begin
            remaining  <= rem_after;
            coin_count <= coin_count + COUNT_W'(1);
            wait_cnt   <= '0;
            coin_value <= sel_code;
            coin_amt   <= sel_value;
            if (rem_after == '0) begin
              state      <= ST_DONE;
              coin_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end else if (stall) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST) begin
              state      <= ST_FAULT;
              coin_valid <= 1'b0;
              busy       <= 1'b0;
              fault      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
